baud_gen_frac: RTL and testbench

Parametrised successor to the fixed-divisor UART baud generator, clocked from the 50 MHz system clock. It produces an oversampled receive strobe and a derived transmit strobe. The divisor is runtime-programmable with a fractional part, so standard baud rates can be hit without the rounding error of an integer divisor. It sits between the register/config logic and the UART Tx/Rx cores; both cores consume single-cycle enable strobes.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/baud_gen_frac_if.sv | 28 ++
 rtl/frac_div_core.sv | 93 +++++++++
 rtl/baud_gen_frac.sv | 73 +++++++
 tb/tb_baud_gen_frac.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART clocking definitions: default widths, 50 MHz divisor
// constants for common baud rates and the divisor record type.
package uart_pkg;

    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;
    localparam int OVS_DEF    = 16;

    // 50 MHz / (baud * 16), split into integer and 1/16 fractional parts
    localparam int DIV_9600_INT    = 325;
    localparam int DIV_9600_FRAC   = 8;
    localparam int DIV_115200_INT  = 27;
    localparam int DIV_115200_FRAC = 2;

    typedef struct packed {
        logic [DIV_W_DEF-1:0]  int_part;
        logic [FRAC_W_DEF-1:0] frac_part;
    } divisor_t;

endpackage

// File: rtl/baud_gen_frac_if.sv
// Configuration and strobe bundle between the register block, the baud
// generator and the UART Tx/Rx cores.
interface baud_gen_frac_if
    import uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
);

    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              rx_tick;
    logic              tx_tick;
    logic              cfg_err;

    modport master (
        output en, div_int, div_frac, div_load,
        input  rx_tick, tx_tick, cfg_err
    );

    modport slave (
        input  en, div_int, div_frac, div_load,
        output rx_tick, tx_tick, cfg_err
    );

endinterface

// File: rtl/frac_div_core.sv
// Fractional clock divider: down-counter with a fractional accumulator
// that stretches a period by one cycle on each accumulator carry. Holds
// the active divisor and the pending shadow, and produces the rx strobe.
module frac_div_core #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int DIV_RST_INT  = 325,
    parameter int DIV_RST_FRAC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic              i_div_load,
    output logic              o_rx_tick,
    output logic              o_reload,
    output logic              o_apply,
    output logic              o_apply_bad
);

    localparam logic [DIV_W-1:0] RST_CNT = (DIV_RST_INT < 2) ? DIV_W'(1) : DIV_W'(DIV_RST_INT - 1);

    logic [DIV_W-1:0]  r_a_int;
    logic [FRAC_W-1:0] r_a_frac;
    logic [DIV_W-1:0]  r_sh_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic              r_pend;
    logic [DIV_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_rx_tick;

    logic              w_reload;
    logic              w_apply;
    logic [DIV_W-1:0]  w_next_int;
    logic [FRAC_W-1:0] w_next_frac;
    logic [DIV_W-1:0]  w_e_m1;
    logic [FRAC_W:0]   w_sum;

    // Reload detection, pending-divisor application and next-period arithmetic
    always_comb begin
        w_reload    = i_en && (r_cnt == '0);
        w_apply     = r_pend && (!i_en || w_reload);
        w_next_int  = w_apply ? r_sh_int  : r_a_int;
        w_next_frac = w_apply ? r_sh_frac : r_a_frac;
        w_e_m1      = (w_next_int < DIV_W'(2)) ? DIV_W'(1) : (w_next_int - DIV_W'(1));
        w_sum       = {1'b0, r_acc} + {1'b0, w_next_frac};
    end

    // Divisor shadow/active registers, period counter and fractional accumulator
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_int   <= DIV_W'(DIV_RST_INT);
            r_a_frac  <= FRAC_W'(DIV_RST_FRAC);
            r_sh_int  <= '0;
            r_sh_frac <= '0;
            r_pend    <= 1'b0;
            r_cnt     <= RST_CNT;
            r_acc     <= '0;
            r_rx_tick <= 1'b0;
        end else begin
            if (w_apply) begin
                r_a_int  <= r_sh_int;
                r_a_frac <= r_sh_frac;
            end
            if (i_div_load) begin
                r_sh_int  <= i_div_int;
                r_sh_frac <= i_div_frac;
                r_pend    <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
            if (!i_en) begin
                r_cnt     <= w_e_m1;
                r_acc     <= '0;
                r_rx_tick <= 1'b0;
            end else if (w_reload) begin
                r_cnt     <= w_e_m1 + DIV_W'(w_sum[FRAC_W]);
                r_acc     <= w_sum[FRAC_W-1:0];
                r_rx_tick <= 1'b1;
            end else begin
                r_cnt     <= r_cnt - DIV_W'(1);
                r_rx_tick <= 1'b0;
            end
        end
    end

    assign o_rx_tick   = r_rx_tick;
    assign o_reload    = w_reload;
    assign o_apply     = w_apply;
    assign o_apply_bad = (r_sh_int < DIV_W'(2));

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional UART baud generator: oversampled rx strobe from the divider
// core, tx strobe on every OVS-th rx strobe, and a sticky flag for an
// out-of-range integer divisor.
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int DIV_W        = DIV_W_DEF,
    parameter int FRAC_W       = FRAC_W_DEF,
    parameter int OVS          = OVS_DEF,
    parameter int DIV_RST_INT  = DIV_9600_INT,
    parameter int DIV_RST_FRAC = DIV_9600_FRAC
) (
    input logic             clk,
    input logic             reset,
    baud_gen_frac_if.slave  bus
);

    localparam int              OVS_W    = $clog2(OVS);
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

    logic             w_rx_tick;
    logic             w_reload;
    logic             w_apply;
    logic             w_apply_bad;
    logic [OVS_W-1:0] r_ovs_cnt;
    logic             r_tx_tick;
    logic             r_cfg_err;

    frac_div_core #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .DIV_RST_INT  (DIV_RST_INT),
        .DIV_RST_FRAC (DIV_RST_FRAC)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .i_en        (bus.en),
        .i_div_int   (bus.div_int),
        .i_div_frac  (bus.div_frac),
        .i_div_load  (bus.div_load),
        .o_rx_tick   (w_rx_tick),
        .o_reload    (w_reload),
        .o_apply     (w_apply),
        .o_apply_bad (w_apply_bad)
    );

    // Oversample counter, tx strobe and divisor range flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovs_cnt <= '0;
            r_tx_tick <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            if (w_apply) begin
                r_cfg_err <= w_apply_bad;
            end
            if (!bus.en) begin
                r_ovs_cnt <= '0;
                r_tx_tick <= 1'b0;
            end else if (w_reload) begin
                r_tx_tick <= (r_ovs_cnt == OVS_LAST);
                r_ovs_cnt <= (r_ovs_cnt == OVS_LAST) ? '0 : (r_ovs_cnt + OVS_W'(1));
            end else begin
                r_tx_tick <= 1'b0;
            end
        end
    end

    assign bus.rx_tick = w_rx_tick;
    assign bus.tx_tick = r_tx_tick;
    assign bus.cfg_err = r_cfg_err;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: a table of divisor settings with
// hand-computed period statistics, plus directed multi-cycle sequences.
module tb_baud_gen_frac;

    logic clk;
    logic reset;
    int   asserts;
    int   fails;
    int   txCount;
    int   orphanTx;

    typedef struct {
        int divInt;
        int divFrac;
        int nIntervals;
        int expFirst;
        int expTotal;
        int expLong;
        int expTx;
        int expErr;
    } vec_t;

    vec_t vecs[6];

    baud_gen_frac_if #(.DIV_W(16), .FRAC_W(4)) bus ();

    baud_gen_frac dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz-style free-running clock for simulation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the bench always terminates
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        asserts++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.tx_tick && !bus.rx_tick) orphanTx++;
        if (bus.tx_tick) txCount++;
    endtask

    task automatic waitRx(input int limit, output int edges, output logic sawTx);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!bus.rx_tick && edges < limit);
        checkOutput("rxArrived", int'(bus.rx_tick), 1);
        sawTx = bus.tx_tick;
    endtask

    task automatic waitTx(input int limit, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!bus.tx_tick && edges < limit);
        checkOutput("txArrived", int'(bus.tx_tick), 1);
    endtask

    // Disable the generator and load a divisor while idle; it is active after return
    task automatic applyStimulus(input int di, input int df);
        bus.en = 1'b0;
        tick();
        bus.div_int  = di[15:0];
        bus.div_frac = df[3:0];
        bus.div_load = 1'b1;
        tick();
        bus.div_load = 1'b0;
        tick();
    endtask

    // Main stimulus sequence
    initial begin
        int   edges;
        int   total;
        int   longCnt;
        int   rxCnt;
        int   quiet;
        logic sawTx;

        asserts  = 0;
        fails    = 0;
        txCount  = 0;
        orphanTx = 0;

        vecs[0] = '{divInt: 10, divFrac: 0,  nIntervals: 16, expFirst: 10, expTotal: 160, expLong: 0,  expTx: 1, expErr: 0};
        vecs[1] = '{divInt: 10, divFrac: 4,  nIntervals: 64, expFirst: 10, expTotal: 656, expLong: 16, expTx: 4, expErr: 0};
        vecs[2] = '{divInt: 1,  divFrac: 0,  nIntervals: 8,  expFirst: 2,  expTotal: 16,  expLong: 0,  expTx: 0, expErr: 1};
        vecs[3] = '{divInt: 0,  divFrac: 15, nIntervals: 8,  expFirst: 2,  expTotal: 23,  expLong: 7,  expTx: 0, expErr: 1};
        vecs[4] = '{divInt: 2,  divFrac: 8,  nIntervals: 8,  expFirst: 2,  expTotal: 20,  expLong: 4,  expTx: 0, expErr: 0};
        vecs[5] = '{divInt: 3,  divFrac: 15, nIntervals: 16, expFirst: 3,  expTotal: 63,  expLong: 15, expTx: 1, expErr: 0};

        bus.en       = 1'b0;
        bus.div_int  = '0;
        bus.div_frac = '0;
        bus.div_load = 1'b0;
        reset        = 1'b0;

        // Reset defaults and the 325/8 power-on divisor
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstRx", int'(bus.rx_tick), 0);
        checkOutput("rstTx", int'(bus.tx_tick), 0);
        checkOutput("rstErr", int'(bus.cfg_err), 0);
        reset  = 1'b1;
        bus.en = 1'b1;
        txCount = 0;
        waitRx(400, edges, sawTx);
        checkOutput("defFirstRx", edges, 325);
        total = edges;
        waitRx(400, edges, sawTx);
        checkOutput("defPeriod2", edges, 325);
        total += edges;
        waitRx(400, edges, sawTx);
        checkOutput("defPeriod3", edges, 326);
        total += edges;
        waitRx(400, edges, sawTx);
        checkOutput("defPeriod4", edges, 325);
        total += edges;
        waitTx(6000, edges);
        checkOutput("defFirstTx", total + edges, 5207);
        waitTx(6000, edges);
        checkOutput("defTxSpacing", edges, 5208);

        // Table of divisor settings
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].divInt, vecs[v].divFrac);
            checkOutput($sformatf("v%0d cfgErr", v), int'(bus.cfg_err), vecs[v].expErr);
            bus.en  = 1'b1;
            txCount = 0;
            waitRx(400, edges, sawTx);
            checkOutput($sformatf("v%0d first", v), edges, vecs[v].expFirst);
            total   = 0;
            longCnt = 0;
            for (int i = 0; i < vecs[v].nIntervals; i++) begin
                waitRx(400, edges, sawTx);
                total += edges;
                if (edges == vecs[v].expFirst + 1) longCnt++;
            end
            checkOutput($sformatf("v%0d total", v), total, vecs[v].expTotal);
            checkOutput($sformatf("v%0d long", v), longCnt, vecs[v].expLong);
            checkOutput($sformatf("v%0d txCount", v), txCount, vecs[v].expTx);
        end

        // Mid-period reload 10 -> 20: current period completes, ovs phase kept
        applyStimulus(10, 0);
        bus.en = 1'b1;
        waitRx(400, edges, sawTx);
        rxCnt = 1;
        repeat (3) tick();
        bus.div_int  = 16'd20;
        bus.div_frac = 4'd0;
        bus.div_load = 1'b1;
        tick();
        bus.div_load = 1'b0;
        waitRx(400, edges, sawTx);
        checkOutput("midLoadCurPeriod", edges + 4, 10);
        rxCnt++;
        waitRx(400, edges, sawTx);
        checkOutput("midLoadNewPeriod", edges, 20);
        rxCnt++;
        while (!sawTx && rxCnt < 40) begin
            waitRx(400, edges, sawTx);
            rxCnt++;
        end
        checkOutput("midLoadTxPhase", rxCnt, 16);

        // Clamped divisor, run-time repair, and a load coincident with a reload
        applyStimulus(1, 0);
        checkOutput("div1CfgErr", int'(bus.cfg_err), 1);
        bus.en = 1'b1;
        waitRx(400, edges, sawTx);
        waitRx(400, edges, sawTx);
        checkOutput("div1Period", edges, 2);
        bus.div_int  = 16'd4;
        bus.div_load = 1'b1;
        tick();
        bus.div_load = 1'b0;
        checkOutput("cfgErrBeforeApply", int'(bus.cfg_err), 1);
        tick();
        checkOutput("reloadApplyRx", int'(bus.rx_tick), 1);
        checkOutput("cfgErrCleared", int'(bus.cfg_err), 0);
        waitRx(400, edges, sawTx);
        checkOutput("div4Period", edges, 4);
        repeat (3) tick();
        bus.div_int  = 16'd6;
        bus.div_load = 1'b1;
        tick();
        checkOutput("sameCycleReloadRx", int'(bus.rx_tick), 1);
        bus.div_load = 1'b0;
        waitRx(400, edges, sawTx);
        checkOutput("sameCycleOldKept", edges, 4);
        waitRx(400, edges, sawTx);
        checkOutput("sameCycleNewApplied", edges, 6);

        // Enable dropped mid-period, then re-enabled
        repeat (2) tick();
        bus.en = 1'b0;
        quiet  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rx_tick || bus.tx_tick) quiet++;
        end
        checkOutput("idleNoTicks", quiet, 0);
        bus.en = 1'b1;
        waitRx(400, edges, sawTx);
        checkOutput("reenableLatency", edges, 6);
        rxCnt = 1;
        while (!sawTx && rxCnt < 40) begin
            waitRx(400, edges, sawTx);
            rxCnt++;
        end
        checkOutput("reenableTxPhase", rxCnt, 16);

        // Reset mid-run with a load pending: outputs drop, divisor back to 325/8
        applyStimulus(1, 0);
        bus.en = 1'b1;
        waitRx(400, edges, sawTx);
        checkOutput("preResetErr", int'(bus.cfg_err), 1);
        tick();
        bus.div_int  = 16'd9;
        bus.div_load = 1'b1;
        tick();
        checkOutput("preResetRx", int'(bus.rx_tick), 1);
        bus.div_load = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("midResetRx", int'(bus.rx_tick), 0);
        checkOutput("midResetTx", int'(bus.tx_tick), 0);
        checkOutput("midResetErr", int'(bus.cfg_err), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        waitRx(400, edges, sawTx);
        checkOutput("postResetFirst", edges, 325);
        waitRx(400, edges, sawTx);
        checkOutput("postResetPeriod2", edges, 325);
        waitRx(400, edges, sawTx);
        checkOutput("postResetPeriod3", edges, 326);

        checkOutput("orphanTx", orphanTx, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
